div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_if.sv | 22 ++
 rtl/div_ctrl.sv | 105 ++++++++++
 tb/tb_div_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Execute-stage handshake between the pipeline and the iterative divider.
// Operands and controls flow master -> slave; stall, result and ready flow back.
interface div_if;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        cancel;
    logic        stall_div;
    logic [63:0] result;
    logic        ready;

    modport master (
        output start, signed_div, opa, opb, cancel,
        input  stall_div, result, ready
    );

    modport slave (
        input  start, signed_div, opa, opb, cancel,
        output stall_div, result, ready
    );
endinterface

// File: rtl/div_ctrl.sv
// 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign applied to magnitudes at the end, result = {remainder, quotient}.
module div_ctrl (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        q_neg;
    logic        r_neg;
    logic [63:0] result_q;
    logic        ready_q;

    logic        accept;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    assign accept    = (state == IDLE) && bus.start && !bus.cancel;
    assign a_mag     = (bus.signed_div && bus.opa[31]) ? neg32(bus.opa) : bus.opa;
    assign b_mag     = (bus.signed_div && bus.opb[31]) ? neg32(bus.opb) : bus.opb;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        rem_sh  = {rem, quo[31]};
        trial   = rem_sh - {1'b0, dvs};
        q_bit   = ~trial[32];
        rem_nxt = q_bit ? trial[31:0] : rem_sh[31:0];
        quo_nxt = {quo[30:0], q_bit};
    end

    // The hazard unit must release the pipeline the moment a flush arrives.
    assign bus.stall_div = !bus.cancel && (accept || state == BUSY);
    assign bus.result    = result_q;
    assign bus.ready     = ready_q;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            dvs      <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            result_q <= 64'h0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (bus.cancel) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (bus.opb == 32'd0) begin
                                result_q <= 64'h0;
                                ready_q  <= 1'b1;
                                state    <= DONE;
                            end else begin
                                quo   <= a_mag;
                                dvs   <= b_mag;
                                rem   <= 32'd0;
                                cnt   <= 5'd0;
                                q_neg <= bus.signed_div && (bus.opa[31] ^ bus.opb[31]);
                                r_neg <= bus.signed_div && bus.opa[31];
                                state <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result_q <= {r_neg ? neg32(rem_nxt) : rem_nxt,
                                         q_neg ? neg32(quo_nxt) : quo_nxt};
                            ready_q  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: arithmetic reference model checked every cycle,
// directed latency/corner cases, then a randomized run.
module tb_div_ctrl;
    logic clk = 1'b0;
    logic rst;
    div_if bus();

    div_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference arithmetic: 64-bit integer division truncates toward zero.
    function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'h0;
        if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Timing model: an accepted op with non-zero divisor busies the unit for 32 cycles.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_res  = 64'h0;
    logic [63:0] m_pend = 64'h0;

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= 64'h0;
        end else if (bus.cancel) begin
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else if (bus.start) begin
            if (bus.opb == 32'd0) begin
                m_done <= 1'b1;
                m_res  <= 64'h0;
            end else begin
                m_left <= 32;
                m_pend <= ref_div(bus.signed_div, bus.opa, bus.opb);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",  {63'd0, bus.ready}, {63'd0, m_done});
            check("result", bus.result, m_res);
            check("stall_div", {63'd0, bus.stall_div},
                  {63'd0, !bus.cancel && (m_left > 0 || (!m_done && bus.start))});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one op in cycle 0 and observe 40 cycles; optional cancel/rst/extra start injections.
    task automatic run_op(input bit sd, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input int rst_at, input int busy_start_at,
                          output int ready_at, output int stall_n);
        bus.start = 1'b1;
        bus.signed_div = sd;
        bus.opa = a;
        bus.opb = b;
        ready_at = -1;
        stall_n  = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == cancel_at) bus.cancel = 1'b1;
            if (c == rst_at) rst = 1'b1;
            if (c == busy_start_at) begin
                bus.start = 1'b1;
                bus.opa = 32'd5;
                bus.opb = 32'd1;
            end
            @(negedge clk);
            if (bus.stall_div) stall_n++;
            if (bus.ready && ready_at < 0) ready_at = c;
            @(posedge clk);
            #1;
            bus.start  = 1'b0;
            bus.cancel = 1'b0;
            rst        = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0, 1:    return $urandom;
            2:       return $urandom_range(0, 20);
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            5:       return 32'd0;
            default: return 32'hFFFF_FFFF - $urandom_range(0, 20);
        endcase
    endfunction

    int ra, sn;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.opa = 32'd0;
        bus.opb = 32'd0;
        bus.cancel = 1'b0;
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("reset_result", bus.result, 64'h0);
        check("reset_ready", {63'd0, bus.ready}, 64'd0);
        cyc(1);
        check("post_reset_stall", {63'd0, bus.stall_div}, 64'd0);

        run_op(1'b0, 32'd100, 32'd0, -1, -1, -1, ra, sn);
        check("zero_ready_cycle", 64'(ra), 64'd1);
        check("zero_stall_cycles", 64'(sn), 64'd1);
        check("zero_result", bus.result, 64'h0);

        run_op(1'b0, 32'd100, 32'd7, -1, -1, -1, ra, sn);
        check("divu_ready_cycle", 64'(ra), 64'd33);
        check("divu_stall_cycles", 64'(sn), 64'd33);
        check("divu_result", bus.result, {32'd2, 32'd14});

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, -1, ra, sn);
        check("div_neg_result", bus.result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, ra, sn);
        check("div_min_stall_cycles", 64'(sn), 64'd33);
        check("div_min_result", bus.result, {32'h0000_0000, 32'h8000_0000});

        run_op(1'b0, 32'd100, 32'd7, 10, -1, -1, ra, sn);
        check("cancel_no_ready", 64'(ra), 64'hFFFF_FFFF_FFFF_FFFF);
        check("cancel_stall_cycles", 64'(sn), 64'd10);
        check("cancel_result_held", bus.result, {32'h0000_0000, 32'h8000_0000});

        run_op(1'b0, 32'd9, 32'd2, -1, -1, 5, ra, sn);
        check("after_cancel_ready_cycle", 64'(ra), 64'd33);
        check("after_cancel_result", bus.result, {32'd1, 32'd4});

        run_op(1'b0, 32'd100, 32'd7, -1, 20, -1, ra, sn);
        check("rst_no_ready", 64'(ra), 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_stall_cycles", 64'(sn), 64'd21);
        check("rst_result", bus.result, 64'h0);

        for (int i = 0; i < 4000; i++) begin
            bus.start      = ($urandom_range(0, 2) == 0);
            bus.signed_div = $urandom_range(0, 1);
            bus.opa        = pick();
            bus.opb        = pick();
            bus.cancel     = ($urandom_range(0, 39) == 0);
            rst            = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        rst        = 1'b0;
        cyc(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
